reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Parametrised register file: one write port, two independent read ports (A, B).
- Registered reads with write-first bypass.
- Optional hardwired-zero entry 0.
- Soft-clear sequencer that zeroes every entry one address per clock.
- Serves as the operand store for datapath blocks needing two operands per cycle.
- Generalises the existing 8x8 single-read register file.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- ADDR_WIDTH, 3, address bits; depth = 2**ADDR_WIDTH.
- ZERO_REG0, 0, when 1 entry 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to the read address is forwarded (write-first); when 0 read returns the old value (read-first).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- write_enable  input  1  write strobe, sampled on rising clock edge
- write_address  input  ADDR_WIDTH  write index
- write_data  input  DATA_WIDTH  write value
- read_address_a  input  ADDR_WIDTH  port A read index
- read_data_a  output  DATA_WIDTH  port A data, registered
- read_address_b  input  ADDR_WIDTH  port B read index
- read_data_b  output  DATA_WIDTH  port B data, registered
- clear_start  input  1  single-cycle pulse, starts soft clear
- clear_busy  output  1  high while soft clear in progress

Behaviour:
- Reset (synchronous, active-high):
  - All entries become 0 on the edge where reset=1.
  - read_data_a = 0, read_data_b = 0, clear_busy = 0.
  - Sequencer returns to IDLE.
  - Reset wins over write_enable, clear_start and an in-progress clear.
- Write:
  - If write_enable=1, not clear_busy, and not (ZERO_REG0=1 and write_address=0): mem[write_address] <= write_data on the edge.
- Read latency is 1 cycle:
  - read_data_x on edge N+1 reflects read_address_x sampled at edge N.
- Same-cycle write and read to the same address:
  - BYPASS=1: read_data_x = write_data.
  - BYPASS=0: read_data_x = previous contents.
- Both read ports may address the same entry; both return identical data.
- ZERO_REG0=1: a read of address 0 returns 0 regardless of writes or bypass.
- Soft-clear state machine (IDLE, CLEAR):
  - IDLE -> CLEAR when clear_start=1. Internal clear_ptr <= 0 and clear_busy <= 1 on that edge.
  - CLEAR: each cycle mem[clear_ptr] <= 0 and clear_ptr increments.
  - On the edge that clears entry DEPTH-1: -> IDLE, clear_busy <= 0.
  - Total: clear_busy high for exactly DEPTH cycles.
  - clear_start asserted during CLEAR is ignored (no restart).
  - Writes during CLEAR are dropped silently.
  - Reads during CLEAR remain live and return current contents. Entries not yet cleared show old data.
  - clear_ptr wraps at DEPTH-1 without overflow; its width is ADDR_WIDTH.
  - A write_enable in the same cycle as clear_start is performed; the clear starts on the following cycle and later zeroes that entry.
- All address inputs are fully decoded; no out-of-range case exists.

Decomposition:
- Shared package reg_file_pkg:
  - state enum {IDLE, CLEAR}.
  - Default DATA_WIDTH/ADDR_WIDTH constants.
- Sub-module reg_file_clear_seq: the IDLE/CLEAR FSM and clear_ptr. Outputs clear_busy, clear_ptr, clear_we.
- Storage array and read/bypass muxing stay in the top module.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3, ZERO_REG0=0, BYPASS=1 unless stated):
- Write/read sweep:
  - Stimulus: write i*16 to address i for i=0..7, then read A=i and B=7-i.
  - Required: one cycle later read_data_a=i*16 and read_data_b=(7-i)*16 (e.g. A=0x30 and B=0x40 for i=3).
- Bypass:
  - Stimulus: in one cycle write 0xA5 to address 2 with read_address_a=2.
  - Required: next cycle read_data_a=0xA5.
  - Same stimulus with BYPASS=0 and prior content 0x20: read_data_a=0x20, then 0xA5 on the following cycle.
- Zero register:
  - Stimulus: ZERO_REG0=1, write 0xFF to address 0, read A=0 and B=0 in the same cycle.
  - Required: both ports 0x00.
- Soft clear:
  - Stimulus: fill all entries with 0x77, pulse clear_start, attempt a write of 0x11 to address 5 at cycle 3 of the clear.
  - Required: clear_busy high exactly 8 cycles; afterwards all reads = 0x00; the write is dropped.
  - A second clear_start mid-clear does not extend busy.
- Reset mid-clear:
  - Stimulus: assert reset at cycle 4 of a clear.
  - Required: next cycle clear_busy=0, both read_data outputs = 0, all entries read 0x00.
  - A subsequent write of 0x3C to address 6 then reads back 0x3C.

Source files
------------

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared types and default sizing for the 2R1W register file.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    // Default geometry: 8 entries of 8 bits
    localparam int c_DEFAULT_DATA_WIDTH = 8;
    localparam int c_DEFAULT_ADDR_WIDTH = 3;

    // Soft-clear sequencer states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_clear_seq
// Description : Soft-clear sequencer. Walks clear_ptr from 0 to DEPTH-1,
//               requesting one zero-write per clock, then returns to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear_start,
    output logic                  o_clear_busy,
    output logic [ADDR_WIDTH-1:0] o_clear_ptr,
    output logic                  o_clear_we
);

    localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = '1;

    clear_state_t            r_state;
    clear_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   w_ptr_next;
    logic                    r_busy;
    logic                    w_busy_next;

    // State, pointer and busy flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_busy  <= w_busy_next;
        end
    end

    // Next-state logic; a start pulse while clearing is ignored
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_busy_next  = r_busy;
        case (r_state)
            IDLE: begin
                if (i_clear_start) begin
                    w_state_next = CLEAR;
                    w_ptr_next   = '0;
                    w_busy_next  = 1'b1;
                end
            end
            CLEAR: begin
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == c_PTR_LAST) begin
                    w_state_next = IDLE;
                    w_busy_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign o_clear_busy = r_busy;
    assign o_clear_ptr  = r_ptr;
    assign o_clear_we   = (r_state == CLEAR);

endmodule : reg_file_clear_seq
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_2r1w
// Description : Register file with one write port and two registered read
//               ports, optional write-first bypass, optional hardwired-zero
//               entry 0 and a one-entry-per-clock soft-clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG0  = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_address_a,
    output logic [DATA_WIDTH-1:0] read_data_a,
    input  logic [ADDR_WIDTH-1:0] read_address_b,
    output logic [DATA_WIDTH-1:0] read_data_b,
    input  logic                  clear_start,
    output logic                  clear_busy
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];
    logic                   w_clear_busy;
    logic [ADDR_WIDTH-1:0]  w_clear_ptr;
    logic                   w_clear_we;
    logic                   w_wr_en;

    reg_file_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk           (clock),
        .rst           (reset),
        .i_clear_start (clear_start),
        .o_clear_busy  (w_clear_busy),
        .o_clear_ptr   (w_clear_ptr),
        .o_clear_we    (w_clear_we)
    );

    // User writes are dropped while clearing and when aimed at a hardwired zero
    assign w_wr_en = write_enable && !w_clear_busy &&
                     !((ZERO_REG0 != 0) && (write_address == '0));

    // Storage array: reset and soft clear zero entries, otherwise user writes
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clear_we) begin
            r_mem[w_clear_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[write_address] <= write_data;
        end
    end

    // One identical read pipeline per port (0 = A, 1 = B)
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_next;
        logic [DATA_WIDTH-1:0] r_data;

        assign w_addr = (gi == 0) ? read_address_a : read_address_b;

        // Read source select: hardwired zero, then forwarded write, then array
        always_comb begin
            w_next = r_mem[w_addr];
            if ((ZERO_REG0 != 0) && (w_addr == '0)) begin
                w_next = '0;
            end else if ((BYPASS != 0) && w_wr_en && (write_address == w_addr)) begin
                w_next = write_data;
            end
        end

        // Registered read data
        always_ff @(posedge clock) begin
            if (reset) begin
                r_data <= '0;
            end else begin
                r_data <= w_next;
            end
        end
    end

    assign read_data_a = g_rd_port[0].r_data;
    assign read_data_b = g_rd_port[1].r_data;
    assign clear_busy  = w_clear_busy;

endmodule : reg_file_2r1w
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_2r1w
// Description : Scoreboard bench for reg_file_2r1w. Instance 0 uses default
//               parameters, instance 1 is read-first (BYPASS=0), instance 2
//               has a hardwired-zero entry 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;

    typedef struct {
        int         inst;
        logic [7:0] ea;
        logic [7:0] eb;
        int         tag;
    } exp_t;

    logic       clk;
    logic       rst   [3];
    logic       we    [3];
    logic [2:0] wa    [3];
    logic [7:0] wd    [3];
    logic [2:0] ra    [3];
    logic [2:0] rb    [3];
    logic [7:0] rda   [3];
    logic [7:0] rdb   [3];
    logic       cs    [3];
    logic       busy  [3];

    exp_t sb[$];
    logic chk;
    logic r_pend;
    int   chk_inst;
    int   tag_cnt;
    int   checks;
    int   failures;

    reg_file_2r1w u_dut0 (
        .clock(clk), .reset(rst[0]), .write_enable(we[0]), .write_address(wa[0]),
        .write_data(wd[0]), .read_address_a(ra[0]), .read_data_a(rda[0]),
        .read_address_b(rb[0]), .read_data_b(rdb[0]), .clear_start(cs[0]),
        .clear_busy(busy[0])
    );

    reg_file_2r1w #(.BYPASS(0)) u_dut1 (
        .clock(clk), .reset(rst[1]), .write_enable(we[1]), .write_address(wa[1]),
        .write_data(wd[1]), .read_address_a(ra[1]), .read_data_a(rda[1]),
        .read_address_b(rb[1]), .read_data_b(rdb[1]), .clear_start(cs[1]),
        .clear_busy(busy[1])
    );

    reg_file_2r1w #(.ZERO_REG0(1)) u_dut2 (
        .clock(clk), .reset(rst[2]), .write_enable(we[2]), .write_address(wa[2]),
        .write_data(wd[2]), .read_address_a(ra[2]), .read_data_a(rda[2]),
        .read_address_b(rb[2]), .read_data_b(rdb[2]), .clear_start(cs[2]),
        .clear_busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A read issued before an edge is presented after it
    always @(posedge clk) r_pend <= chk;

    // Monitor: pop one expectation per presented read and compare both ports
    always @(negedge clk) begin
        if (r_pend) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                failures = failures + 1;
                $display("FAIL scoreboard_empty: read presented with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rda[e.inst] !== e.ea || rdb[e.inst] !== e.eb) begin
                    failures = failures + 1;
                    $display("FAIL read#%0d inst%0d: got a=%02h b=%02h, expected a=%02h b=%02h",
                             e.tag, e.inst, rda[e.inst], rdb[e.inst], e.ea, e.eb);
                end
            end
        end
    end

    task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Advance to the next drive point and drop single-cycle strobes
    task automatic cycle();
        @(negedge clk);
        chk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0;
            cs[i] = 1'b0;
        end
    endtask

    task automatic wr(input int inst, input logic [2:0] addr, input logic [7:0] data);
        we[inst] = 1'b1;
        wa[inst] = addr;
        wd[inst] = data;
    endtask

    task automatic rd(input int inst, input logic [2:0] aa, input logic [2:0] ab,
                      input logic [7:0] ea, input logic [7:0] eb);
        exp_t e;
        ra[inst] = aa;
        rb[inst] = ab;
        chk      = 1'b1;
        e.inst   = inst;
        e.ea     = ea;
        e.eb     = eb;
        e.tag    = tag_cnt;
        tag_cnt  = tag_cnt + 1;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        tag_cnt  = 0;
        chk      = 1'b0;
        chk_inst = 0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; we[i] = 1'b0; wa[i] = '0; wd[i] = '0;
            ra[i]  = '0;   rb[i] = '0;   cs[i] = 1'b0;
        end
        cycle();
        cycle();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("reset_rda%0d", i), rda[i], 8'h00);
            check_eq($sformatf("reset_rdb%0d", i), rdb[i], 8'h00);
            check_eq($sformatf("reset_busy%0d", i), {7'd0, busy[i]}, 8'h00);
            rst[i] = 1'b0;
        end

        // Write/read sweep on the default instance
        for (int i = 0; i < 8; i++) begin
            cycle(); wr(0, 3'(i), 8'(i * 16));
        end
        for (int i = 0; i < 8; i++) begin
            cycle(); rd(0, 3'(i), 3'(7 - i), 8'(i * 16), 8'((7 - i) * 16));
        end

        // Write-first bypass on port A, then on port B
        cycle(); wr(0, 3'd2, 8'hA5); rd(0, 3'd2, 3'd7, 8'hA5, 8'h70);
        cycle(); wr(0, 3'd5, 8'h3B); rd(0, 3'd1, 3'd5, 8'h10, 8'h3B);

        // Read-first instance: old value, then new value
        cycle(); wr(1, 3'd2, 8'h20);
        cycle(); wr(1, 3'd2, 8'hA5); rd(1, 3'd2, 3'd2, 8'h20, 8'h20);
        cycle(); rd(1, 3'd2, 3'd0, 8'hA5, 8'h00);

        // Hardwired zero entry: writes ignored and never forwarded
        cycle(); wr(2, 3'd0, 8'hFF);
        cycle(); wr(2, 3'd0, 8'hEE); rd(2, 3'd0, 3'd0, 8'h00, 8'h00);
        cycle(); wr(2, 3'd1, 8'h5A); rd(2, 3'd0, 3'd1, 8'h00, 8'h5A);

        // Soft clear: fill, start, drop a write, ignore a restart
        for (int i = 0; i < 8; i++) begin
            cycle(); wr(0, 3'(i), 8'h77);
        end
        cycle();
        check_eq("busy_before_clear", {7'd0, busy[0]}, 8'h00);
        cs[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check_eq($sformatf("busy_clear_cycle%0d", k), {7'd0, busy[0]}, 8'h01);
            if (k == 2) rd(0, 3'd7, 3'd0, 8'h77, 8'h00);
            if (k == 3) begin
                wr(0, 3'd5, 8'h11);
                rd(0, 3'd5, 3'd5, 8'h77, 8'h77);
            end
            if (k == 4) begin
                cs[0] = 1'b1;
                rd(0, 3'd5, 3'd1, 8'h77, 8'h00);
            end
        end
        cycle();
        check_eq("busy_after_clear", {7'd0, busy[0]}, 8'h00);
        cycle();
        check_eq("busy_no_restart", {7'd0, busy[0]}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cycle(); rd(0, 3'(i), 3'(7 - i), 8'h00, 8'h00);
        end

        // Reset in the middle of a clear
        for (int i = 0; i < 8; i++) begin
            cycle(); wr(0, 3'(i), 8'h99);
        end
        cycle(); cs[0] = 1'b1;
        for (int k = 1; k <= 3; k++) cycle();
        cycle();
        rst[0] = 1'b1;
        wr(0, 3'd6, 8'h55);
        ra[0] = 3'd7;
        rb[0] = 3'd6;
        cycle();
        rst[0] = 1'b0;
        check_eq("rst_mid_busy", {7'd0, busy[0]}, 8'h00);
        check_eq("rst_mid_rda", rda[0], 8'h00);
        check_eq("rst_mid_rdb", rdb[0], 8'h00);
        for (int i = 0; i < 8; i++) begin
            cycle(); rd(0, 3'(i), 3'(7 - i), 8'h00, 8'h00);
        end
        cycle(); wr(0, 3'd6, 8'h3C);
        cycle(); rd(0, 3'd6, 3'd6, 8'h3C, 8'h3C);
        cycle();
        cycle();

        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL read#%0d inst%0d: never presented, expected a=%02h b=%02h",
                     e.tag, e.inst, e.ea, e.eb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_2r1w
`default_nettype wire
